// File: rtl/capture_readout.sv
`default_nettype none
// ============================================================================
//  Module      : capture_readout
//  Description : Streams a completed circular capture buffer out in write
//                order, starting at the oldest sample (end_addr+1) and
//                flagging the trigger sample and the final sample. Each
//                sample takes one buffer read (FETCH), one cycle of read
//                latency (WAIT) and a ready/valid handshake (SEND).
//  Option      : define CAPTURE_READOUT_HEADER_EN to emit one header word
//                (the trigger offset from the oldest sample) before the
//                samples.
//  Revision    : 1.0  initial release
// ============================================================================
module capture_readout #(
   parameter int ADDR_W = 10,   // buffer holds 2**ADDR_W samples
   parameter int DATA_W = 16    // must be >= ADDR_W so the header offset fits
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start_read,
   input  logic              abort,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic [ADDR_W-1:0] trig_addr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_trig,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   // HEADER only exists when the header word option is built in.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
`ifdef CAPTURE_READOUT_HEADER_EN
      HEADER = 3'd1,
`endif
      FETCH  = 3'd2,
      WAIT   = 3'd3,
      SEND   = 3'd4
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] base_q;      // address of the oldest sample
   logic [ADDR_W-1:0] trig_q;      // latched trigger address
   logic [ADDR_W-1:0] count_q;     // index of the sample in flight
   logic              rd_en_q;
   logic [ADDR_W-1:0] rd_addr_q;   // also base+count of the sample in flight
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              out_trig_q;
   logic              out_last_q;
   logic              busy_q;
   logic              done_q;

   // Oldest sample sits just past the last written one; wraps naturally.
   logic [ADDR_W-1:0] start_base_d;
   // Address of the sample following the one in flight.
   logic [ADDR_W-1:0] addr_next_d;

   assign start_base_d = end_addr + ADDR_W'(1);
   assign addr_next_d  = base_q + count_q + ADDR_W'(1);

`ifdef CAPTURE_READOUT_HEADER_EN
   // Trigger position relative to the oldest sample, modulo buffer depth.
   logic [ADDR_W-1:0] hdr_off_d;
   assign hdr_off_d = trig_addr - start_base_d;
`endif

   // Readout sequencer; every output is driven straight from a register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         base_q      <= '0;
         trig_q      <= '0;
         count_q     <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_trig_q  <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // Strobes last a single cycle unless re-asserted below.
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;

         if ((state_q != IDLE) && abort) begin
            // Cancel wins over any handshake in flight; no completion pulse.
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_trig_q  <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_read && !abort) begin
                     base_q  <= start_base_d;
                     trig_q  <= trig_addr;
                     count_q <= '0;
                     busy_q  <= 1'b1;
`ifdef CAPTURE_READOUT_HEADER_EN
                     out_data_q  <= DATA_W'(hdr_off_d);
                     out_valid_q <= 1'b1;
                     out_trig_q  <= 1'b0;
                     out_last_q  <= 1'b0;
                     state_q     <= HEADER;
`else
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= start_base_d;
                     state_q   <= FETCH;
`endif
                  end
               end

`ifdef CAPTURE_READOUT_HEADER_EN
               HEADER: begin
                  // Hold the header word until it is taken, then read sample 0.
                  if (out_ready) begin
                     out_valid_q <= 1'b0;
                     rd_en_q     <= 1'b1;
                     rd_addr_q   <= base_q;
                     state_q     <= FETCH;
                  end
               end
`endif

               FETCH: begin
                  // Read strobe is already on the pins; wait for the data.
                  state_q <= WAIT;
               end

               WAIT: begin
                  out_data_q  <= rd_data;
                  out_valid_q <= 1'b1;
                  out_trig_q  <= (rd_addr_q == trig_q);
                  out_last_q  <= (&count_q);
                  state_q     <= SEND;
               end

               SEND: begin
                  if (out_ready) begin
                     out_valid_q <= 1'b0;
                     out_trig_q  <= 1'b0;
                     out_last_q  <= 1'b0;
                     if (&count_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                     end else begin
                        count_q   <= count_q + ADDR_W'(1);
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= addr_next_d;
                        state_q   <= FETCH;
                     end
                  end
               end

               default: begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  out_trig_q  <= 1'b0;
                  out_last_q  <= 1'b0;
                  busy_q      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_trig  = out_trig_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_capture_readout
//  Description : Self-checking bench for capture_readout (ADDR_W=3). A
//                registered buffer model answers reads; expected streams are
//                built from modular address arithmetic over that buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_capture_readout;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;

   logic              clock;
   logic              reset;
   logic              start_read;
   logic              abort;
   logic [ADDR_W-1:0] end_addr;
   logic [ADDR_W-1:0] trig_addr;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_trig;
   logic              out_last;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] mem [DEPTH];

   int n_checks = 0;
   int n_errors = 0;

   capture_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .start_read(start_read),
      .abort     (abort),
      .end_addr  (end_addr),
      .trig_addr (trig_addr),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_trig  (out_trig),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Buffer model: data appears one cycle after the read strobe.
   always @(posedge clock) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One full readout. abort_word/stall_word/spur_cyc < 0 disable that event.
   task automatic do_readout(input int e, input int t, input int ready_pct,
                             input int abort_word, input int stall_word, input int spur_cyc);
      logic [DATA_W-1:0] exp_data [$];
      bit                exp_trig [$];
      bit                exp_last [$];
      int                exp_addr [$];
      int base, nwords, widx, rdx, cyc, dones, stall_cnt, first_cyc, exp_lat, a;
      bit hold, rdy;
      logic [DATA_W-1:0] hold_data;

      base = (e + 1) % DEPTH;
`ifdef CAPTURE_READOUT_HEADER_EN
      exp_data.push_back(DATA_W'((t - base + DEPTH) % DEPTH));
      exp_trig.push_back(1'b0);
      exp_last.push_back(1'b0);
      exp_lat = 0;
`else
      exp_lat = 2;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         a = (base + k) % DEPTH;
         exp_addr.push_back(a);
         exp_data.push_back(mem[a]);
         exp_trig.push_back(a == t);
         exp_last.push_back(k == DEPTH - 1);
      end

      @(negedge clock);
      end_addr   = ADDR_W'(e);
      trig_addr  = ADDR_W'(t);
      start_read = 1'b1;
      abort      = 1'b0;
      out_ready  = 1'b0;
      @(negedge clock);
      start_read = 1'b0;

      nwords = exp_data.size();
      widx = 0; rdx = 0; cyc = 0; dones = 0; stall_cnt = 0; first_cyc = -1; hold = 1'b0;
      while (widx < nwords && cyc < 400) begin
         start_read = 1'b0;
         if (cyc == spur_cyc) begin
            start_read = 1'b1;
            end_addr   = ADDR_W'(e + 3);
         end
         check_eq("busy_run", busy, 1);
         if (rd_en) begin
            if (rdx < exp_addr.size()) check_eq("rd_addr", rd_addr, exp_addr[rdx]);
            else check_eq("rd_en_extra", rd_en, 0);
            rdx++;
            if (out_valid) check_eq("rd_en_while_valid", rd_en, 0);
         end
         if (hold) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, hold_data);
         end
         dones += int'(done);
         hold = 1'b0;
         if (out_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (widx == abort_word) begin
               abort     = 1'b1;
               out_ready = 1'($urandom_range(0, 1));
               @(negedge clock);
               abort = 1'b0;
               check_eq("abort_valid", out_valid, 0);
               check_eq("abort_rd_en", rd_en, 0);
               check_eq("abort_trig", out_trig, 0);
               check_eq("abort_last", out_last, 0);
               check_eq("abort_busy", busy, 0);
               check_eq("abort_done", done, 0);
               @(negedge clock);
               check_eq("abort_done2", done, 0);
               check_eq("abort_busy2", busy, 0);
               out_ready = 1'b0;
               return;
            end
            if (widx == stall_word && stall_cnt < 10) begin
               rdy = 1'b0;
               stall_cnt++;
            end else begin
               rdy = ($urandom_range(0, 99) < ready_pct);
            end
            out_ready = rdy;
            if (rdy) begin
               check_eq("out_data", out_data, exp_data[widx]);
               check_eq("out_trig", out_trig, exp_trig[widx]);
               check_eq("out_last", out_last, exp_last[widx]);
               widx++;
            end else begin
               hold      = 1'b1;
               hold_data = out_data;
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clock);
         cyc++;
      end
      start_read = 1'b0;
      check_eq("timeout_words", widx, nwords);
      check_eq("first_latency", first_cyc, exp_lat);
      dones += int'(done);
      check_eq("end_busy", busy, 0);
      check_eq("end_valid", out_valid, 0);
      out_ready = 1'b0;
      @(negedge clock);
      dones += int'(done);
      check_eq("done_count", dones, 1);
      check_eq("fetch_count", rdx, DEPTH);
   endtask

   initial begin
      reset      = 1'b1;
      start_read = 1'b0;
      abort      = 1'b0;
      out_ready  = 1'b0;
      end_addr   = '0;
      trig_addr  = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(16'h10 + i);
      repeat (3) @(negedge clock);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_trig", out_trig, 0);
      check_eq("rst_last", out_last, 0);
      check_eq("rst_rd_en", rd_en, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_rd_addr", rd_addr, 0);
      reset = 1'b0;

      // Wrapped readout, trigger at 0x11.
      do_readout(5, 1, 100, -1, -1, -1);
      // No wrap: addresses 0..7.
      do_readout(7, 3, 100, -1, -1, -1);
      // Downstream stalls for 10 cycles on the third word.
      do_readout(5, 1, 100, -1, 2, -1);
      // Cancel during the fourth word, then a fresh readout from the oldest.
      do_readout(5, 1, 100, 3, -1, -1);
      do_readout(5, 1, 100, -1, -1, -1);

      // Reset while waiting on buffer read data.
      @(negedge clock);
      end_addr   = 3'd5;
      trig_addr  = 3'd1;
      start_read = 1'b1;
      out_ready  = 1'b1;
      @(negedge clock);
      start_read = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_valid", out_valid, 0);
      check_eq("mid_rst_rd_en", rd_en, 0);
      check_eq("mid_rst_done", done, 0);
      check_eq("mid_rst_trig", out_trig, 0);
      check_eq("mid_rst_last", out_last, 0);
      check_eq("mid_rst_data", out_data, 0);
      check_eq("mid_rst_addr", rd_addr, 0);
      reset     = 1'b0;
      out_ready = 1'b0;
      @(negedge clock);
      check_eq("post_rst_busy", busy, 0);
      check_eq("post_rst_done", done, 0);

      // A second start_read while busy must not restart the readout.
      do_readout(5, 1, 70, -1, -1, 4);

      // Randomized buffers, pointers and backpressure.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
         do_readout(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                    60, -1, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
